// File: rtl/wr_timebase_gen.sv
// wr_timebase_gen: local TAI-seconds / reference-cycles timebase with a
// runtime-programmable second length, time load, PPS pulse plus stretched
// LED output, and independent armed timestamp trigger channels.
module wr_timebase_gen #(
  parameter int unsigned g_tai_width    = 40,
  parameter int unsigned g_cycles_width = 28,
  parameter int unsigned g_num_triggers = 2,
  parameter int unsigned g_pps_width    = 10
) (
  input  logic                                     clk_ref_i,
  input  logic                                     rst_n_i,
  input  logic [g_cycles_width-1:0]                period_i,
  input  logic                                     load_i,
  input  logic [g_tai_width-1:0]                   load_tai_i,
  input  logic [g_cycles_width-1:0]                load_cycles_i,
  output logic [g_tai_width-1:0]                   tm_tai_o,
  output logic [g_cycles_width-1:0]                tm_cycles_o,
  output logic                                     tm_valid_o,
  output logic                                     pps_p_o,
  output logic                                     pps_led_o,
  input  logic [g_num_triggers-1:0]                trig_arm_i,
  input  logic [g_num_triggers*g_tai_width-1:0]    trig_tai_i,
  input  logic [g_num_triggers*g_cycles_width-1:0] trig_cycles_i,
  output logic [g_num_triggers-1:0]                trig_armed_o,
  output logic [g_num_triggers-1:0]                trig_p_o,
  output logic [g_num_triggers-1:0]                trig_late_o
);

  localparam int unsigned c_led_w = $clog2(g_pps_width + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } t_trig_state;

  logic [g_tai_width-1:0]    r_tai;
  logic [g_cycles_width-1:0] r_cycles;
  logic                      r_valid;
  logic                      r_pps_p;
  logic [c_led_w-1:0]        r_pps_cnt;
  logic                      w_rollover;

  // A load always wins; otherwise a count at or beyond the last cycle of the
  // second wraps, so shrinking the period or loading a large count self-heals.
  assign w_rollover = !load_i && (r_cycles >= period_i);

  // Seconds/cycles counter; it free-runs even before the first load.
  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tai    <= '0;
      r_cycles <= '0;
      r_valid  <= 1'b0;
    end else if (load_i) begin
      r_tai    <= load_tai_i;
      r_cycles <= load_cycles_i;
      r_valid  <= 1'b1;
    end else if (w_rollover) begin
      r_tai    <= r_tai + g_tai_width'(1);
      r_cycles <= '0;
    end else begin
      r_cycles <= r_cycles + g_cycles_width'(1);
    end
  end

  // PPS pulse lands in the same cycle the counter shows the wrapped zero;
  // the stretch counter reloads on every pulse so back-to-back PPS extend it.
  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pps_p   <= 1'b0;
      r_pps_cnt <= '0;
    end else begin
      r_pps_p <= w_rollover;
      if (w_rollover) begin
        r_pps_cnt <= c_led_w'(g_pps_width);
      end else if (r_pps_cnt != '0) begin
        r_pps_cnt <= r_pps_cnt - c_led_w'(1);
      end
    end
  end

  assign tm_tai_o    = r_tai;
  assign tm_cycles_o = r_cycles;
  assign tm_valid_o  = r_valid;
  assign pps_p_o     = r_pps_p;
  assign pps_led_o   = (r_pps_cnt != '0);

  for (genvar k = 0; k < g_num_triggers; k++) begin : g_trig
    t_trig_state               r_state;
    logic [g_tai_width-1:0]    r_tgt_tai;
    logic [g_cycles_width-1:0] r_tgt_cycles;
    logic                      r_fire;
    logic                      r_late;
    logic                      w_reached;
    logic                      w_past;

    // Lexicographic unsigned compare of current time against the target.
    assign w_reached = (r_tai > r_tgt_tai) ||
                       ((r_tai == r_tgt_tai) && (r_cycles >= r_tgt_cycles));
    assign w_past    = (r_tai > r_tgt_tai) ||
                       ((r_tai == r_tgt_tai) && (r_cycles > r_tgt_cycles));

    // Arm strobe takes priority over a simultaneous fire so a re-arm in the
    // compare cycle replaces the target silently instead of pulsing.
    always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_state      <= ST_IDLE;
        r_tgt_tai    <= '0;
        r_tgt_cycles <= '0;
        r_fire       <= 1'b0;
        r_late       <= 1'b0;
      end else if (trig_arm_i[k]) begin
        r_state      <= ST_ARMED;
        r_tgt_tai    <= trig_tai_i[k*g_tai_width +: g_tai_width];
        r_tgt_cycles <= trig_cycles_i[k*g_cycles_width +: g_cycles_width];
        r_fire       <= 1'b0;
        r_late       <= 1'b0;
      end else if ((r_state == ST_ARMED) && w_reached) begin
        r_state <= ST_IDLE;
        r_fire  <= 1'b1;
        r_late  <= w_past;
      end else begin
        r_fire <= 1'b0;
        r_late <= 1'b0;
      end
    end

    assign trig_armed_o[k] = (r_state == ST_ARMED);
    assign trig_p_o[k]     = r_fire;
    assign trig_late_o[k]  = r_late;
  end

endmodule

// File: tb/tb_wr_timebase_gen.sv
// tb_wr_timebase_gen: directed scoreboard bench for wr_timebase_gen.
module tb_wr_timebase_gen;

  localparam int TW = 40;
  localparam int CW = 28;
  localparam int NT = 2;

  logic            clk_ref_i;
  logic            rst_n_i;
  logic [CW-1:0]   period_i;
  logic            load_i;
  logic [TW-1:0]   load_tai_i;
  logic [CW-1:0]   load_cycles_i;
  logic [TW-1:0]   tm_tai_o;
  logic [CW-1:0]   tm_cycles_o;
  logic            tm_valid_o;
  logic            pps_p_o;
  logic            pps_led_o;
  logic [NT-1:0]   trig_arm_i;
  logic [NT*TW-1:0] trig_tai_i;
  logic [NT*CW-1:0] trig_cycles_i;
  logic [NT-1:0]   trig_armed_o;
  logic [NT-1:0]   trig_p_o;
  logic [NT-1:0]   trig_late_o;

  typedef struct {
    string       tag;
    logic [63:0] value;
  } t_exp;

  t_exp sbQueue[$];
  int   vectors = 0;
  int   miscompares = 0;

  wr_timebase_gen #(
    .g_tai_width   (TW),
    .g_cycles_width(CW),
    .g_num_triggers(NT),
    .g_pps_width   (10)
  ) dut (
    .clk_ref_i    (clk_ref_i),
    .rst_n_i      (rst_n_i),
    .period_i     (period_i),
    .load_i       (load_i),
    .load_tai_i   (load_tai_i),
    .load_cycles_i(load_cycles_i),
    .tm_tai_o     (tm_tai_o),
    .tm_cycles_o  (tm_cycles_o),
    .tm_valid_o   (tm_valid_o),
    .pps_p_o      (pps_p_o),
    .pps_led_o    (pps_led_o),
    .trig_arm_i   (trig_arm_i),
    .trig_tai_i   (trig_tai_i),
    .trig_cycles_i(trig_cycles_i),
    .trig_armed_o (trig_armed_o),
    .trig_p_o     (trig_p_o),
    .trig_late_o  (trig_late_o)
  );

  // Free-running reference clock, rising edges at 5, 15, 25, ...
  initial clk_ref_i = 1'b0;
  always #5 clk_ref_i = ~clk_ref_i;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_ref_i);
    #1;
  endtask

  task automatic expectVal(input string tag, input logic [63:0] value);
    t_exp e;
    e.tag   = tag;
    e.value = value;
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput(input logic [63:0] obs);
    t_exp e;
    vectors++;
    if (sbQueue.size() == 0) begin
      miscompares++;
      $error("[TB] FAIL scoreboard_empty: observed %0h, expected nothing queued", obs);
    end else begin
      e = sbQueue.pop_front();
      assert (obs === e.value) else begin
        miscompares++;
        $error("[TB] FAIL %s: observed %0h expected %0h", e.tag, obs, e.value);
      end
    end
  endtask

  // Drive one cycle of load and/or arm strobes, then drop them after the edge.
  task automatic applyStimulus(input logic ld, input logic [TW-1:0] ldTai,
                               input logic [CW-1:0] ldCyc, input logic [NT-1:0] armMask,
                               input logic [TW-1:0] armTai, input logic [CW-1:0] armCyc);
    load_i        = ld;
    load_tai_i    = ldTai;
    load_cycles_i = ldCyc;
    trig_arm_i    = armMask;
    trig_tai_i    = {NT{armTai}};
    trig_cycles_i = {NT{armCyc}};
    tick(1);
    load_i     = 1'b0;
    trig_arm_i = '0;
  endtask

  initial begin
    rst_n_i       = 1'b0;
    period_i      = CW'(999);
    load_i        = 1'b0;
    load_tai_i    = '0;
    load_cycles_i = '0;
    trig_arm_i    = '0;
    trig_tai_i    = '0;
    trig_cycles_i = '0;

    // Reset state
    #1;
    expectVal("rst_tai", 0);     checkOutput(64'(tm_tai_o));
    expectVal("rst_cycles", 0);  checkOutput(64'(tm_cycles_o));
    expectVal("rst_valid", 0);   checkOutput(64'(tm_valid_o));
    expectVal("rst_pps", 0);     checkOutput(64'(pps_p_o));
    expectVal("rst_armed", 0);   checkOutput(64'(trig_armed_o));
    #11;
    rst_n_i = 1'b1;

    // Counter runs before any load, time not yet valid
    tick(5);
    expectVal("free_cycles", 5); checkOutput(64'(tm_cycles_o));
    expectVal("free_valid", 0);  checkOutput(64'(tm_valid_o));

    // Load 100/0: valid next cycle, no PPS from the load
    applyStimulus(1'b1, TW'(100), CW'(0), 2'b00, '0, '0);
    expectVal("load_tai", 100);  checkOutput(64'(tm_tai_o));
    expectVal("load_cycles", 0); checkOutput(64'(tm_cycles_o));
    expectVal("load_valid", 1);  checkOutput(64'(tm_valid_o));
    expectVal("load_no_pps", 0); checkOutput(64'(pps_p_o));

    // Full 1000-cycle second, then PPS and 10-cycle LED stretch
    tick(999);
    expectVal("sec_end_cycles", 999); checkOutput(64'(tm_cycles_o));
    expectVal("sec_end_pps", 0);      checkOutput(64'(pps_p_o));
    tick(1);
    expectVal("roll_tai", 101);   checkOutput(64'(tm_tai_o));
    expectVal("roll_cycles", 0);  checkOutput(64'(tm_cycles_o));
    expectVal("roll_pps", 1);     checkOutput(64'(pps_p_o));
    expectVal("roll_led", 1);     checkOutput(64'(pps_led_o));
    tick(1);
    expectVal("pps_one_cycle", 0); checkOutput(64'(pps_p_o));
    tick(8);
    expectVal("led_last", 1);      checkOutput(64'(pps_led_o));
    tick(1);
    expectVal("led_off", 0);       checkOutput(64'(pps_led_o));

    // Arm ch0 for 102/250 while time is 101/900
    tick(890);
    expectVal("pre_arm_cycles", 900); checkOutput(64'(tm_cycles_o));
    applyStimulus(1'b0, '0, '0, 2'b01, TW'(102), CW'(250));
    expectVal("ch0_armed", 1);   checkOutput(64'(trig_armed_o));
    tick(349);
    expectVal("ch0_meet_tai", 102);    checkOutput(64'(tm_tai_o));
    expectVal("ch0_meet_cycles", 250); checkOutput(64'(tm_cycles_o));
    expectVal("ch0_meet_nopulse", 0);  checkOutput(64'(trig_p_o));
    tick(1);
    expectVal("ch0_fire", 1);    checkOutput(64'(trig_p_o));
    expectVal("ch0_ontime", 0);  checkOutput(64'(trig_late_o));
    expectVal("ch0_disarm", 0);  checkOutput(64'(trig_armed_o));
    tick(1);
    expectVal("ch0_pulse_end", 0); checkOutput(64'(trig_p_o));

    // Shrink period 999 -> 499 at cycles = 700: immediate wrap
    tick(448);
    expectVal("pre_shrink_cycles", 700); checkOutput(64'(tm_cycles_o));
    period_i = CW'(499);
    tick(1);
    expectVal("shrink_cycles", 0); checkOutput(64'(tm_cycles_o));
    expectVal("shrink_tai", 103);  checkOutput(64'(tm_tai_o));
    expectVal("shrink_pps", 1);    checkOutput(64'(pps_p_o));
    tick(499);
    expectVal("short_end", 499);   checkOutput(64'(tm_cycles_o));
    expectVal("short_nopps", 0);   checkOutput(64'(pps_p_o));
    tick(1);
    expectVal("short_roll_tai", 104); checkOutput(64'(tm_tai_o));
    expectVal("short_roll_pps", 1);   checkOutput(64'(pps_p_o));

    // Arm ch1 with a target already in the past: late fire at arm + 2
    tick(10);
    applyStimulus(1'b0, '0, '0, 2'b10, TW'(50), CW'(0));
    expectVal("ch1_armed", 2'b10);  checkOutput(64'(trig_armed_o));
    expectVal("ch1_wait", 0);       checkOutput(64'(trig_p_o));
    tick(1);
    expectVal("ch1_fire", 2'b10);   checkOutput(64'(trig_p_o));
    expectVal("ch1_late", 2'b10);   checkOutput(64'(trig_late_o));
    expectVal("ch1_disarm", 0);     checkOutput(64'(trig_armed_o));
    tick(1);
    expectVal("ch1_pulse_end", 0);  checkOutput(64'(trig_p_o));

    // Both armed for 200/0; backward load keeps them waiting
    applyStimulus(1'b0, '0, '0, 2'b11, TW'(200), CW'(0));
    expectVal("both_armed", 2'b11); checkOutput(64'(trig_armed_o));
    applyStimulus(1'b1, TW'(10), CW'(0), 2'b00, '0, '0);
    expectVal("back_tai", 10);      checkOutput(64'(tm_tai_o));
    expectVal("back_nopps", 0);     checkOutput(64'(pps_p_o));
    tick(1);
    expectVal("back_armed", 2'b11); checkOutput(64'(trig_armed_o));
    expectVal("back_nofire", 0);    checkOutput(64'(trig_p_o));

    // Forward load past the target: both channels fire late together
    applyStimulus(1'b1, TW'(300), CW'(0), 2'b00, '0, '0);
    expectVal("fwd_tai", 300);      checkOutput(64'(tm_tai_o));
    expectVal("fwd_nopps", 0);      checkOutput(64'(pps_p_o));
    tick(1);
    expectVal("fwd_fire", 2'b11);   checkOutput(64'(trig_p_o));
    expectVal("fwd_late", 2'b11);   checkOutput(64'(trig_late_o));
    expectVal("fwd_disarm", 0);     checkOutput(64'(trig_armed_o));

    // Re-arm ch0 in its compare cycle: no pulse, new target 301/0 kept
    applyStimulus(1'b0, '0, '0, 2'b01, TW'(300), CW'(5));
    tick(3);
    expectVal("rearm_at_cycles", 5); checkOutput(64'(tm_cycles_o));
    applyStimulus(1'b0, '0, '0, 2'b01, TW'(301), CW'(0));
    expectVal("rearm_nopulse", 0);   checkOutput(64'(trig_p_o));
    expectVal("rearm_armed", 2'b01); checkOutput(64'(trig_armed_o));
    tick(494);
    expectVal("rearm_meet_tai", 301); checkOutput(64'(tm_tai_o));
    expectVal("rearm_meet_wait", 0);  checkOutput(64'(trig_p_o));
    tick(1);
    expectVal("rearm_fire", 2'b01);  checkOutput(64'(trig_p_o));
    expectVal("rearm_ontime", 0);    checkOutput(64'(trig_late_o));

    // TAI wrap: load all-ones / 999 with period 499
    applyStimulus(1'b1, {TW{1'b1}}, CW'(999), 2'b00, '0, '0);
    expectVal("max_tai", 64'hFF_FFFF_FFFF); checkOutput(64'(tm_tai_o));
    expectVal("max_nopps", 0);              checkOutput(64'(pps_p_o));
    tick(1);
    expectVal("wrap_tai", 0);     checkOutput(64'(tm_tai_o));
    expectVal("wrap_cycles", 0);  checkOutput(64'(tm_cycles_o));
    expectVal("wrap_pps", 1);     checkOutput(64'(pps_p_o));

    // Asynchronous reset mid-stretch with channels armed
    applyStimulus(1'b0, '0, '0, 2'b11, TW'(5000), CW'(0));
    expectVal("prerst_armed", 2'b11); checkOutput(64'(trig_armed_o));
    expectVal("prerst_led", 1);       checkOutput(64'(pps_led_o));
    #2;
    rst_n_i = 1'b0;
    #1;
    expectVal("arst_cycles", 0);  checkOutput(64'(tm_cycles_o));
    expectVal("arst_valid", 0);   checkOutput(64'(tm_valid_o));
    expectVal("arst_led", 0);     checkOutput(64'(pps_led_o));
    expectVal("arst_armed", 0);   checkOutput(64'(trig_armed_o));
    #2;
    rst_n_i = 1'b1;
    tick(3);
    expectVal("resume_cycles", 3); checkOutput(64'(tm_cycles_o));
    expectVal("resume_valid", 0);  checkOutput(64'(tm_valid_o));
    expectVal("resume_armed", 0);  checkOutput(64'(trig_armed_o));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
